// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, control bundle, decoder opcodes.
// Combinational helpers only; no timing or backpressure of their own.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [6:0] LD_OP      = 7'b0000011;
  localparam logic [6:0] JALR_OP    = 7'b1100111;
  localparam logic [6:0] SB_TYPE_OP = 7'b1100011;
  localparam logic [6:0] UJ_TYPE_OP = 7'b1101111;

  typedef struct packed {
    logic pc_write;
    logic pc_sel_branch;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic back_write;
  } ctl_t;

  function automatic logic load_use_hit(
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic use_rs1, input logic use_rs2,
    input logic ex_load, input logic [4:0] ex_rd
  );
    return ex_load && (ex_rd != REG_X0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

  // Issue-cycle controls once memory is not holding the pipe: a load-use
  // stall masks a redirect so the branch re-resolves with forwarded data.
  function automatic ctl_t issue_ctl(input logic load_use, input logic redirect);
    ctl_t c;
    c = '0;
    if (load_use) begin
      c.id_ex_bubble = 1'b1;
      c.back_write   = 1'b1;
    end else if (redirect) begin
      c.pc_write      = 1'b1;
      c.pc_sel_branch = 1'b1;
      c.if_id_flush   = 1'b1;
      c.back_write    = 1'b1;
    end else begin
      c.pc_write    = 1'b1;
      c.if_id_write = 1'b1;
      c.back_write  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard unit bundle: ID/EX/MEM status in, pipeline enables and counters out.
// Pure wiring; the slave side is the controller, the master side is the pipeline.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             id_redirect;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             pc_sel_branch;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             back_write;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           id_redirect, mem_req, dmem_ready,
    input  pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_bubble,
           back_write, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           id_redirect, mem_req, dmem_ready,
    output pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_bubble,
           back_write, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
// One-cycle update latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, ID redirects, memory freeze with timeout halt.
// Controls are same-cycle combinational; FSM and counters update on the next edge.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  ctl_t       ctl;
  logic       load_use;
  logic       mem_stall;

  always_comb begin
    load_use  = load_use_hit(bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2,
                             bus.ex_mem_read, bus.ex_rd);
    mem_stall = bus.mem_req && !bus.dmem_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctl     = '0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else begin
          ctl = issue_ctl(load_use, bus.id_redirect);
        end
      end
      MEM_WAIT: begin
        // The completing cycle issues normally; the MEM request is retiring.
        if (bus.dmem_ready) begin
          ctl     = issue_ctl(load_use, bus.id_redirect);
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == MAX_WAIT_C) begin
          state_d = HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (reset) begin
      ctl              = '0;
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
    end
  end

  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_sel_branch = ctl.pc_sel_branch;
  assign bus.if_id_write   = ctl.if_id_write;
  assign bus.if_id_flush   = ctl.if_id_flush;
  assign bus.id_ex_bubble  = ctl.id_ex_bubble;
  assign bus.back_write    = ctl.back_write;
  assign bus.halted        = (state_q == HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (!ctl.pc_write),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (ctl.if_id_flush),
    .cnt (bus.flush_cnt)
  );

endmodule
